inv_mix_columns_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 50 +++++
 rtl/inv_mix_single_column.sv | 24 ++
 rtl/inv_mix_columns_iter.sv | 74 +++++++
 tb/tb_inv_mix_columns_iter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: state width, GF(2^8) constant multipliers and the
// InvMixColumns sequencer state encoding.
package aes_pkg;

    localparam int AES_STATE_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } imc_state_t;

    // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x;
    endfunction

    function automatic logic [7:0] gf_mulb(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ x;
    endfunction

    function automatic logic [7:0] gf_muld(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    function automatic logic [7:0] gf_mule(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// Combinational InvMixColumns on one 32-bit column, row 0 in the top byte.
module inv_mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    logic [7:0] w_b0, w_b1, w_b2, w_b3;

    assign w_a0 = i_col[31:24];
    assign w_a1 = i_col[23:16];
    assign w_a2 = i_col[15:8];
    assign w_a3 = i_col[7:0];

    assign w_b0 = gf_mule(w_a0) ^ gf_mulb(w_a1) ^ gf_muld(w_a2) ^ gf_mul9(w_a3);
    assign w_b1 = gf_mul9(w_a0) ^ gf_mule(w_a1) ^ gf_mulb(w_a2) ^ gf_muld(w_a3);
    assign w_b2 = gf_muld(w_a0) ^ gf_mul9(w_a1) ^ gf_mule(w_a2) ^ gf_mulb(w_a3);
    assign w_b3 = gf_mulb(w_a0) ^ gf_muld(w_a1) ^ gf_mul9(w_a2) ^ gf_mule(w_a3);

    assign o_col = {w_b0, w_b1, w_b2, w_b3};

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one shared column transform, applied to
// columns 3..0 on successive cycles, result held until downstream takes it.
module inv_mix_columns_iter
    import aes_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [AES_STATE_W-1:0] i_state,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [AES_STATE_W-1:0] o_state,
    output logic                   o_valid,
    input  logic                   i_ready
);

    imc_state_t             r_state;
    imc_state_t             w_next_state;
    logic [1:0]             r_cnt;
    logic [AES_STATE_W-1:0] r_work;
    logic [31:0]            w_col_in;
    logic [31:0]            w_col_out;

    assign w_col_in = r_work[{r_cnt, 5'd0} +: 32];

    inv_mix_single_column u_col (
        .i_col (w_col_in),
        .o_col (w_col_out)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (i_valid)        w_next_state = ST_BUSY;
            ST_BUSY: if (r_cnt == 2'd0)  w_next_state = ST_DONE;
            ST_DONE: if (i_ready)        w_next_state = ST_IDLE;
            default:                     w_next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs decode only the registered state
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (r_state)
            ST_IDLE: o_ready = 1'b1;
            ST_DONE: o_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= 2'd0;
            r_work <= '0;
        end else if (r_state == ST_IDLE && i_valid) begin
            r_cnt  <= 2'd3;
            r_work <= i_state;
        end else if (r_state == ST_BUSY) begin
            r_cnt                      <= r_cnt - 2'd1;
            r_work[{r_cnt, 5'd0} +: 32] <= w_col_out;
        end
    end

    assign o_state = r_work;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Self-checking bench for inv_mix_columns_iter: directed vectors, handshake
// corner cases, mid-operation reset and a MixColumns round trip.
module tb_inv_mix_columns_iter;

    logic         i_clk;
    logic         i_rst_n;
    logic [127:0] i_state;
    logic         i_valid;
    logic         o_ready;
    logic [127:0] o_state;
    logic         o_valid;
    logic         i_ready;

    int checks = 0;
    int errors = 0;

    inv_mix_columns_iter dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_state (i_state),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_state (o_state),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Encryption-side MixColumns, used to build round-trip inputs
    function automatic logic [7:0] tbXtime(input logic [7:0] x);
        return x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    endfunction

    function automatic logic [127:0] mixColumns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c+24 +: 8];
            a1 = s[32*c+16 +: 8];
            a2 = s[32*c+8  +: 8];
            a3 = s[32*c    +: 8];
            r[32*c+24 +: 8] = tbXtime(a0) ^ tbXtime(a1) ^ a1 ^ a2 ^ a3;
            r[32*c+16 +: 8] = a0 ^ tbXtime(a1) ^ tbXtime(a2) ^ a2 ^ a3;
            r[32*c+8  +: 8] = a0 ^ a1 ^ tbXtime(a2) ^ tbXtime(a3) ^ a3;
            r[32*c    +: 8] = tbXtime(a0) ^ a0 ^ a1 ^ a2 ^ tbXtime(a3);
        end
        return r;
    endfunction

    // Present one state and wait (bounded) for o_valid; returns cycles from accept edge
    task automatic applyStimulus(input string tag, input logic [127:0] st, output int lat);
        int waitCnt;
        waitCnt = 0;
        while (!o_ready && waitCnt < 20) begin
            @(posedge i_clk); #1;
            waitCnt++;
        end
        checkOutput({tag, " ready"}, {127'd0, o_ready}, 128'd1);
        i_state = st;
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 20) begin
            @(posedge i_clk); #1;
            lat++;
        end
        checkOutput({tag, " valid"}, {127'd0, o_valid}, 128'd1);
    endtask

    task automatic drainOutput(input string tag);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        checkOutput({tag, " valid_fall"}, {127'd0, o_valid}, 128'd0);
        checkOutput({tag, " ready_rise"}, {127'd0, o_ready}, 128'd1);
    endtask

    task automatic runVector(input string tag, input logic [127:0] st, input logic [127:0] exp);
        int lat;
        applyStimulus(tag, st, lat);
        checkOutput({tag, " latency"}, 128'(lat), 128'd4);
        checkOutput({tag, " state"}, o_state, exp);
        drainOutput(tag);
    endtask

    localparam logic [127:0] FIPS_IN  = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    initial begin
        int lat;
        logic [127:0] x;
        logic [31:0] colIn  [4];
        logic [31:0] colOut [4];
        colIn[0] = 32'h8e4da1bc; colOut[0] = 32'hdb135345;
        colIn[1] = 32'h9fdc589d; colOut[1] = 32'hf20a225c;
        colIn[2] = 32'h4d7ebdf8; colOut[2] = 32'h2d26314c;
        colIn[3] = 32'hc6c6c6c6; colOut[3] = 32'hc6c6c6c6;

        i_rst_n = 1'b0;
        i_state = '0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        #12;
        checkOutput("reset o_valid", {127'd0, o_valid}, 128'd0);
        checkOutput("reset o_ready", {127'd0, o_ready}, 128'd1);
        checkOutput("reset o_state", o_state, 128'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        runVector("fips", FIPS_IN, FIPS_OUT);
        for (int k = 0; k < 4; k++) begin
            runVector($sformatf("col%0d", k), {4{colIn[k]}}, {4{colOut[k]}});
        end

        // Backpressure: result held while i_ready is low
        applyStimulus("hold", FIPS_IN, lat);
        for (int k = 0; k < 10; k++) begin
            @(posedge i_clk); #1;
            checkOutput($sformatf("hold%0d state", k), o_state, FIPS_OUT);
            checkOutput($sformatf("hold%0d valid", k), {127'd0, o_valid}, 128'd1);
            checkOutput($sformatf("hold%0d ready", k), {127'd0, o_ready}, 128'd0);
        end
        drainOutput("hold");

        // i_valid pulses while BUSY and DONE must not disturb the result
        i_state = FIPS_IN;
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_state = {4{colIn[0]}};
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 20) begin
            @(posedge i_clk); #1;
            lat++;
        end
        checkOutput("ignore latency", 128'(lat), 128'd4);
        i_valid = 1'b1;
        repeat (3) begin
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        checkOutput("ignore state", o_state, FIPS_OUT);
        checkOutput("ignore valid", {127'd0, o_valid}, 128'd1);
        drainOutput("ignore");

        // Reset two cycles after an accept
        i_state = {4{colIn[1]}};
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(posedge i_clk);
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        #1;
        checkOutput("midrst o_valid", {127'd0, o_valid}, 128'd0);
        checkOutput("midrst o_ready", {127'd0, o_ready}, 128'd1);
        checkOutput("midrst o_state", o_state, 128'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        runVector("after_rst", {4{colIn[2]}}, {4{colOut[2]}});

        // Round trip through MixColumns, including the all-0x80 reduction case
        runVector("rt80", mixColumns({16{8'h80}}), {16{8'h80}});
        for (int n = 0; n < 300; n++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(0, 3)) begin
                @(posedge i_clk); #1;
            end
            applyStimulus("rt", mixColumns(x), lat);
            repeat ($urandom_range(0, 3)) begin
                @(posedge i_clk); #1;
            end
            checkOutput($sformatf("rt%0d state", n), o_state, x);
            drainOutput("rt");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
